// File: rtl/lru_pkg.sv
// Shared types for the LRU update controller: array command encoding,
// controller state encoding and the saturating increment used by the perf counters.
package lru_pkg;

    typedef enum logic [1:0] {
        LRU_INIT   = 2'b00,
        LRU_TOUCH  = 2'b01,
        LRU_ROTATE = 2'b10,
        LRU_HOLD   = 2'b11
    } lru_cmd_t;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_UPD       = 3'd2,
        ST_VICTIM    = 3'd3,
        ST_WAIT_FILL = 3'd4
    } lru_ctrl_state_t;

    localparam int unsigned PERF_CNT_W = 32;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == {PERF_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lru_perf_cnt.sv
// Saturating 32-bit event counter with enable; clears on asynchronous reset.
module lru_perf_cnt
    import lru_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    output logic [PERF_CNT_W-1:0] cnt_o
);

    logic [PERF_CNT_W-1:0] cnt_q;
    logic [PERF_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lru_update_ctrl.sv
// Sequencer issuing init / touch / hold commands to the per-set LRU age array.
// Optional hit/miss counters are built when LRU_PERF_CNT_EN is defined.
module lru_update_ctrl
    import lru_pkg::*;
#(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Lookup handshake: a lookup transfers on a cycle where req_valid and
    // req_ready are both high; req_ready is high only in IDLE.
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_hit,
    input  logic [INDEX_SIZE-1:0]     req_index,
    input  logic [$clog2(ASSOC)-1:0]  req_way,
    output logic                      victim_valid,
    output logic [INDEX_SIZE-1:0]     victim_index,
    output logic [$clog2(ASSOC)-1:0]  victim_way,
    input  logic                      fill_done,
    output logic [1:0]                lru_replace,
    output logic [INDEX_SIZE-1:0]     lru_index,
    output logic [$clog2(ASSOC)-1:0]  lru_assoc,
    input  logic [$clog2(ASSOC)-1:0]  lru_way,
    output logic                      init_done,
    output lru_ctrl_state_t           dbg_state
`ifdef LRU_PERF_CNT_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt
`endif
);

    localparam int WAY_W = $clog2(ASSOC);

    lru_ctrl_state_t       state_q, state_d;
    logic [INDEX_SIZE-1:0] idx_q, idx_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  hit_q, hit_d;
    logic                  init_done_q, init_done_d;
    logic                  accept;
    lru_cmd_t              cmd;

    assign accept = (state_q == ST_IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:      state_d = ST_IDLE;
            ST_IDLE:      if (req_valid) state_d = req_hit ? ST_UPD : ST_VICTIM;
            ST_UPD:       state_d = ST_IDLE;
            ST_VICTIM:    state_d = ST_WAIT_FILL;
            ST_WAIT_FILL: if (fill_done) state_d = ST_UPD;
            default:      state_d = ST_INIT;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        way_d       = way_q;
        hit_d       = hit_q;
        victim_d    = victim_q;
        init_done_d = init_done_q;
        if (accept) begin
            idx_d = req_index;
            way_d = req_way;
            hit_d = req_hit;
        end
        // The array's LRU way is only meaningful while lru_index points at the captured set.
        if (state_q == ST_VICTIM) begin
            victim_d = lru_way;
        end
        if (state_q == ST_INIT) begin
            init_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            way_q       <= '0;
            hit_q       <= 1'b0;
            victim_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            way_q       <= way_d;
            hit_q       <= hit_d;
            victim_q    <= victim_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        req_ready    = 1'b0;
        victim_valid = 1'b0;
        cmd          = LRU_HOLD;
        lru_index    = idx_q;
        lru_assoc    = '0;
        case (state_q)
            ST_INIT: begin
                cmd       = LRU_INIT;
                lru_index = '0;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_UPD: begin
                cmd       = LRU_TOUCH;
                lru_assoc = hit_q ? way_q : victim_q;
            end
            ST_WAIT_FILL: begin
                victim_valid = 1'b1;
            end
            default: begin
                cmd = LRU_HOLD;
            end
        endcase
    end

    assign lru_replace  = cmd;
    assign victim_index = idx_q;
    assign victim_way   = victim_q;
    assign init_done    = init_done_q;
    assign dbg_state    = state_q;

`ifdef LRU_PERF_CNT_EN
    lru_perf_cnt u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (accept && req_hit),
        .cnt_o (hit_cnt)
    );

    lru_perf_cnt u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (accept && !req_hit),
        .cnt_o (miss_cnt)
    );
`endif

endmodule
